// File: rtl/exhaust_fsm_param.sv
// Range-hood fan controller: normal levels, one-shot turbo, menu-driven return countdown.
// Optional run-time seconds counter enabled by defining EXHAUST_RUNTIME_EN.
module exhaust_fsm_param #(
  parameter int unsigned NUM_LEVELS  = 3,
  parameter int unsigned TURBO_SECS  = 60,
  parameter int unsigned RETURN_SECS = 60,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned LVL_W       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  is_on,
  input  logic                  menu_key,
  input  logic [NUM_LEVELS-1:0] level_key,
  output logic [LVL_W-1:0]      mode,
  output logic [CNT_W-1:0]      countdown,
  output logic                  countdown_active,
  output logic                  busy,
  output logic                  turbo_used
`ifdef EXHAUST_RUNTIME_EN
  ,
  output logic [15:0]           run_secs
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StTurbo, StReturn} state_e;

  localparam logic [LVL_W-1:0] TurboLvl  = LVL_W'(NUM_LEVELS);
  localparam logic [LVL_W-1:0] TopNormal = LVL_W'(NUM_LEVELS - 1);
  localparam logic [CNT_W-1:0] TurboCnt  = CNT_W'(TURBO_SECS);
  localparam logic [CNT_W-1:0] ReturnCnt = CNT_W'(RETURN_SECS);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [LVL_W-1:0] mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             used_q, used_d;
  logic             busy_q, busy_d;
  logic             active_q, active_d;

  logic             key_hit;
  logic [LVL_W-1:0] key_lvl;
  logic             turbo_key;
  logic             cnt_tick;

  assign turbo_key = level_key[NUM_LEVELS-1];
  // Guard keeps the countdown from wrapping below zero.
  assign cnt_tick  = tick && (cnt_q != '0);

  // Lowest-index normal key wins; the loop runs downward so the lowest hit is written last.
  always_comb begin
    key_hit = 1'b0;
    key_lvl = '0;
    for (int i = int'(NUM_LEVELS) - 2; i >= 0; i--) begin
      if (level_key[i]) begin
        key_hit = 1'b1;
        key_lvl = LVL_W'(i + 1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    used_d  = used_q;
    if (!is_on) begin
      state_d = StIdle;
      mode_d  = '0;
      cnt_d   = '0;
      used_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (key_hit) begin
            state_d = StRun;
            mode_d  = key_lvl;
          end else if (turbo_key && !used_q) begin
            state_d = StTurbo;
            mode_d  = TurboLvl;
            cnt_d   = TurboCnt;
            used_d  = 1'b1;
          end
        end
        StRun: begin
          if (menu_key) begin
            state_d = StIdle;
            mode_d  = '0;
          end else if (key_hit) begin
            mode_d = key_lvl;
          end
        end
        StTurbo: begin
          if (menu_key) begin
            state_d = StReturn;
            mode_d  = '0;
            cnt_d   = ReturnCnt;
          end else if (cnt_tick) begin
            if (cnt_q == CntOne) begin
              state_d = StRun;
              mode_d  = TopNormal;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CntOne;
            end
          end
        end
        StReturn: begin
          mode_d = '0;
          if (cnt_tick) begin
            if (cnt_q == CntOne) begin
              state_d = StIdle;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CntOne;
            end
          end
        end
        default: begin
          state_d = StIdle;
          mode_d  = '0;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d   = (state_d != StIdle);
    active_d = (state_d == StTurbo) || (state_d == StReturn);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      mode_q   <= '0;
      cnt_q    <= '0;
      used_q   <= 1'b0;
      busy_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      used_q   <= used_d;
      busy_q   <= busy_d;
      active_q <= active_d;
    end
  end

  assign mode             = mode_q;
  assign countdown        = cnt_q;
  assign countdown_active = active_q;
  assign busy             = busy_q;
  assign turbo_used       = used_q;

`ifdef EXHAUST_RUNTIME_EN
  logic [15:0] secs_q;

  // Survives power-off; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      secs_q <= '0;
    end else if (tick && busy_q && (secs_q != 16'hFFFF)) begin
      secs_q <= secs_q + 16'd1;
    end
  end

  assign run_secs = secs_q;
`endif

endmodule

// File: tb/tb_exhaust_fsm_param.sv
// Self-checking bench for exhaust_fsm_param: directed scenarios plus randomized traffic
// against a behavioural model of the fan controller rules.
module tb_exhaust_fsm_param;

  localparam int NL = 3;
  localparam int TS = 5;
  localparam int RS = 3;

  localparam int PH_IDLE   = 0;
  localparam int PH_RUN    = 1;
  localparam int PH_TURBO  = 2;
  localparam int PH_RETURN = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic          is_on = 1'b1;
  logic          menu_key = 1'b0;
  logic [NL-1:0] level_key = '0;
  logic [1:0]    mode;
  logic [7:0]    countdown;
  logic          countdown_active;
  logic          busy;
  logic          turbo_used;
`ifdef EXHAUST_RUNTIME_EN
  logic [15:0]   run_secs;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int ph   = PH_IDLE;
  int md   = 0;
  int cd   = 0;
  bit used = 1'b0;
  int secs = 0;

  exhaust_fsm_param #(
    .NUM_LEVELS (NL),
    .TURBO_SECS (TS),
    .RETURN_SECS(RS),
    .CNT_W      (8),
    .LVL_W      (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .tick            (tick),
    .is_on           (is_on),
    .menu_key        (menu_key),
    .level_key       (level_key),
    .mode            (mode),
    .countdown       (countdown),
    .countdown_active(countdown_active),
    .busy            (busy),
    .turbo_used      (turbo_used)
`ifdef EXHAUST_RUNTIME_EN
    ,
    .run_secs        (run_secs)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    ph = PH_IDLE; md = 0; cd = 0; used = 1'b0; secs = 0;
  endtask

  task automatic model_step(input bit t, input bit mk, input bit [NL-1:0] lk, input bit on);
    int lo;
    bit was_busy;
    was_busy = (ph != PH_IDLE);
    lo = 0;
    for (int i = 1; i < NL; i++) begin
      if (lk[i-1] && lo == 0) lo = i;
    end
    if (!on) begin
      ph = PH_IDLE; md = 0; cd = 0; used = 1'b0;
    end else if (ph == PH_IDLE) begin
      if (lo != 0) begin
        ph = PH_RUN; md = lo;
      end else if (lk[NL-1] && !used) begin
        ph = PH_TURBO; md = NL; cd = TS; used = 1'b1;
      end
    end else if (ph == PH_RUN) begin
      if (mk) begin
        ph = PH_IDLE; md = 0;
      end else if (lo != 0) begin
        md = lo;
      end
    end else if (ph == PH_TURBO) begin
      if (mk) begin
        ph = PH_RETURN; md = 0; cd = RS;
      end else if (t && cd > 0) begin
        cd = cd - 1;
        if (cd == 0) begin
          ph = PH_RUN; md = NL - 1;
        end
      end
    end else begin
      if (t && cd > 0) begin
        cd = cd - 1;
        if (cd == 0) ph = PH_IDLE;
      end
    end
    if (t && was_busy && secs < 65535) secs = secs + 1;
  endtask

  // Applies one cycle of inputs, advances the model, leaves outputs ready to sample.
  task automatic drive(input bit t, input bit mk, input bit [NL-1:0] lk, input bit on);
    @(negedge clk);
    tick = t; menu_key = mk; level_key = lk; is_on = on;
    @(posedge clk);
    model_step(t, mk, lk, on);
    #1;
    tick = 1'b0; menu_key = 1'b0; level_key = '0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_tests++;
    if (mode !== 2'd0 || countdown !== 8'd0 || busy !== 1'b0 || turbo_used !== 1'b0 ||
        countdown_active !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: mode=%0d cd=%0d busy=%b used=%b act=%b, want all 0",
               mode, countdown, busy, turbo_used, countdown_active);
    end
    @(negedge clk) rst = 1'b0;
    model_reset();
    drive(0, 0, 3'b100, 1);
    drive(1, 0, 3'b000, 1);
    drive(1, 0, 3'b000, 1);
    n_tests++;
    if (mode !== 2'd3 || countdown !== 8'd3) begin
      n_fail++;
      $display("FAIL reset_pre_turbo: mode=%0d cd=%0d, want 3/3", mode, countdown);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    n_tests++;
    if (mode !== 2'd0 || countdown !== 8'd0 || busy !== 1'b0 || turbo_used !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_turbo: mode=%0d cd=%0d busy=%b used=%b, want 0/0/0/0",
               mode, countdown, busy, turbo_used);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_levels();
    drive(0, 0, 3'b011, 1);
    n_tests++;
    if (mode !== 2'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL levels_lowest: mode=%0d busy=%b, want 1/1", mode, busy);
    end
    drive(0, 0, 3'b010, 1);
    n_tests++;
    if (mode !== 2'd2) begin
      n_fail++;
      $display("FAIL levels_change: mode=%0d, want 2", mode);
    end
    drive(0, 0, 3'b100, 1);
    n_tests++;
    if (mode !== 2'd2 || turbo_used !== 1'b0) begin
      n_fail++;
      $display("FAIL levels_turbo_in_run: mode=%0d used=%b, want 2/0", mode, turbo_used);
    end
    drive(0, 1, 3'b001, 1);
    n_tests++;
    if (mode !== 2'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL levels_menu: mode=%0d busy=%b, want 0/0", mode, busy);
    end
  endtask

  task automatic test_turbo_expiry();
    drive(0, 0, 3'b100, 1);
    n_tests++;
    if (mode !== 2'd3 || countdown !== 8'd5 || countdown_active !== 1'b1 || turbo_used !== 1'b1)
    begin
      n_fail++;
      $display("FAIL turbo_enter: mode=%0d cd=%0d act=%b used=%b, want 3/5/1/1",
               mode, countdown, countdown_active, turbo_used);
    end
    for (int i = 0; i < 5; i++) drive(1, 0, 3'b000, 1);
    n_tests++;
    if (mode !== 2'd2 || countdown !== 8'd0 || turbo_used !== 1'b1 || countdown_active !== 1'b0)
    begin
      n_fail++;
      $display("FAIL turbo_expire: mode=%0d cd=%0d used=%b act=%b, want 2/0/1/0",
               mode, countdown, turbo_used, countdown_active);
    end
    drive(0, 1, 3'b000, 1);
    drive(0, 0, 3'b100, 1);
    n_tests++;
    if (mode !== 2'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL turbo_once: mode=%0d busy=%b, want 0/0", mode, busy);
    end
  endtask

  task automatic test_power_cycle();
    drive(0, 0, 3'b000, 0);
    n_tests++;
    if (turbo_used !== 1'b0 || mode !== 2'd0) begin
      n_fail++;
      $display("FAIL power_clear: used=%b mode=%0d, want 0/0", turbo_used, mode);
    end
    drive(0, 0, 3'b100, 1);
    n_tests++;
    if (mode !== 2'd3 || countdown !== 8'd5) begin
      n_fail++;
      $display("FAIL power_turbo_again: mode=%0d cd=%0d, want 3/5", mode, countdown);
    end
  endtask

  task automatic test_menu_vs_expiry();
    for (int i = 0; i < 4; i++) drive(1, 0, 3'b000, 1);
    n_tests++;
    if (countdown !== 8'd1) begin
      n_fail++;
      $display("FAIL menu_pre_cd: cd=%0d, want 1", countdown);
    end
    drive(1, 1, 3'b000, 1);
    n_tests++;
    if (mode !== 2'd0 || countdown !== 8'd3 || busy !== 1'b1 || countdown_active !== 1'b1) begin
      n_fail++;
      $display("FAIL menu_beats_expiry: mode=%0d cd=%0d busy=%b act=%b, want 0/3/1/1",
               mode, countdown, busy, countdown_active);
    end
    drive(1, 0, 3'b111, 1);
    drive(1, 1, 3'b111, 1);
    n_tests++;
    if (mode !== 2'd0 || countdown !== 8'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL return_keys_ignored: mode=%0d cd=%0d busy=%b, want 0/1/1",
               mode, countdown, busy);
    end
    drive(1, 0, 3'b011, 1);
    n_tests++;
    if (mode !== 2'd0 || countdown !== 8'd0 || busy !== 1'b0 || countdown_active !== 1'b0) begin
      n_fail++;
      $display("FAIL return_done: mode=%0d cd=%0d busy=%b act=%b, want 0/0/0/0",
               mode, countdown, busy, countdown_active);
    end
  endtask

`ifdef EXHAUST_RUNTIME_EN
  task automatic test_runtime();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    @(negedge clk) rst = 1'b0;
    drive(0, 0, 3'b001, 1);
    for (int i = 0; i < 4; i++) drive(1, 0, 3'b000, 1);
    drive(0, 1, 3'b000, 1);
    for (int i = 0; i < 2; i++) drive(1, 0, 3'b000, 1);
    n_tests++;
    if (run_secs !== 16'd4) begin
      n_fail++;
      $display("FAIL runtime_count: run_secs=%0d, want 4", run_secs);
    end
    drive(0, 0, 3'b001, 1);
    for (int i = 0; i < 65534; i++) drive(1, 0, 3'b000, 1);
    n_tests++;
    if (run_secs !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL runtime_reach_max: run_secs=%0h, want ffff", run_secs);
    end
    drive(1, 0, 3'b000, 1);
    drive(1, 0, 3'b000, 1);
    n_tests++;
    if (run_secs !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL runtime_saturate: run_secs=%0h, want ffff", run_secs);
    end
  endtask
`endif

  task automatic test_random();
    bit          t, mk, on;
    bit [NL-1:0] lk;
    for (int c = 0; c < 600; c++) begin
      t  = ($urandom_range(0, 2) == 0);
      mk = ($urandom_range(0, 5) == 0);
      on = ($urandom_range(0, 24) != 0);
      for (int b = 0; b < NL; b++) lk[b] = ($urandom_range(0, 4) == 0);
      drive(t, mk, lk, on);
      n_tests++;
      if (mode !== 2'(md) || countdown !== 8'(cd) || busy !== (ph != PH_IDLE) ||
          countdown_active !== (ph == PH_TURBO || ph == PH_RETURN) || turbo_used !== used) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: mode=%0d cd=%0d busy=%b act=%b used=%b, want %0d/%0d/%b/%b/%b",
                 c, mode, countdown, busy, countdown_active, turbo_used, md, cd,
                 ph != PH_IDLE, ph == PH_TURBO || ph == PH_RETURN, used);
      end
`ifdef EXHAUST_RUNTIME_EN
      n_tests++;
      if (run_secs !== 16'(secs)) begin
        n_fail++;
        $display("FAIL random_runtime_%0d: run_secs=%0d, want %0d", c, run_secs, secs);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_levels();
    test_turbo_expiry();
    test_power_cycle();
    test_menu_vs_expiry();
`ifdef EXHAUST_RUNTIME_EN
    test_runtime();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
